// File: rtl/register_file.sv
// RV32I integer register file: 32 x 32, two combinational read ports, one write port, x0 hardwired to zero.
// Define REGFILE_BYPASS_EN to forward a same-cycle write to matching read ports.
module register_file #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] rd_data,
  input  logic            rd_we,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data
);

  // x0 has no storage; its reads are forced to zero below.
  logic [XLEN-1:0] r_regs [1:NREGS-1];
  logic            w_wr_en;
  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;

  assign w_wr_en = rd_we && (rd_addr != {AW{1'b0}});

  // Storage looked up for a read address; zero for x0.
  function automatic logic [XLEN-1:0] stored_value(input logic [AW-1:0] addr);
    logic [XLEN-1:0] val;
    if (addr == {AW{1'b0}}) begin
      val = {XLEN{1'b0}};
    end else begin
      val = r_regs[addr];
    end
    return val;
  endfunction

  // Storage update: reset clears x1..x(NREGS-1) and wins over a simultaneous write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NREGS; i++) begin
        r_regs[i] <= {XLEN{1'b0}};
      end
    end else if (w_wr_en) begin
      r_regs[rd_addr] <= rd_data;
    end
  end

  // Read port muxing, with optional write-through forwarding.
  always_comb begin
    w_rs1_data = stored_value(rs1_addr);
    w_rs2_data = stored_value(rs2_addr);
`ifdef REGFILE_BYPASS_EN
    if (!rst && w_wr_en && (rd_addr == rs1_addr)) begin
      w_rs1_data = rd_data;
    end else begin
      w_rs1_data = stored_value(rs1_addr);
    end
    if (!rst && w_wr_en && (rd_addr == rs2_addr)) begin
      w_rs2_data = rd_data;
    end else begin
      w_rs2_data = stored_value(rs2_addr);
    end
`endif
  end

  assign rs1_data = w_rs1_data;
  assign rs2_data = w_rs2_data;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: architectural model compared every cycle plus directed literal checks.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_we;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  int checks;
  int failures;

  logic [31:0] model [0:31];
  logic        model_valid;

  register_file #(.XLEN(32), .NREGS(32), .AW(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_we    (rd_we),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural expectation for one read port given the current inputs.
  function automatic logic [31:0] expect_read(input logic [4:0] addr);
    if (addr == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (!rst && rd_we && rd_addr != 5'd0 && rd_addr == addr) return rd_data;
`endif
    return model[addr];
  endfunction

  // Model state update on each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] <= 32'h0;
      model_valid <= 1'b1;
    end else if (rd_we && rd_addr != 5'd0) begin
      model[rd_addr] <= rd_data;
    end
  end

  // Per-cycle comparison of both read ports against the model.
  always @(negedge clk) begin
    if (model_valid) begin
      chk("model_rs1", rs1_data, expect_read(rs1_addr));
      chk("model_rs2", rs2_data, expect_read(rs2_addr));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] raddrs [4];
    checks = 0;
    failures = 0;
    model_valid = 1'b0;
    rst = 1'b1; rd_we = 1'b0; rd_addr = 5'd0; rd_data = 32'h0;
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    #1;
    chk("x0_before_reset", rs1_data, 32'h0);

    step();
    rst = 1'b0;
    raddrs[0] = 5'd0; raddrs[1] = 5'd1; raddrs[2] = 5'd2; raddrs[3] = 5'd31;
    for (int k = 0; k < 4; k++) begin
      rs1_addr = raddrs[k]; rs2_addr = raddrs[k];
      #1;
      chk("reset_rs1", rs1_data, 32'h0);
      chk("reset_rs2", rs2_data, 32'h0);
    end

    // Basic writes
    rd_we = 1'b1; rd_addr = 5'd1; rd_data = 32'hDEADBEEF;
    step();
    rd_addr = 5'd2; rd_data = 32'hCAFEBABE;
    step();
    rd_we = 1'b0; rs1_addr = 5'd1; rs2_addr = 5'd2;
    #1;
    chk("basic_x1", rs1_data, 32'hDEADBEEF);
    chk("basic_x2", rs2_data, 32'hCAFEBABE);
    step();

    // x0 immutability
    rd_we = 1'b1; rd_addr = 5'd0; rd_data = 32'hFFFFFFFF;
    step();
    rd_we = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd1;
    #1;
    chk("x0_write_dropped", rs1_data, 32'h0);
    chk("x0_x1_kept", rs2_data, 32'hDEADBEEF);
    rs2_addr = 5'd2;
    #1;
    chk("x0_x2_kept", rs2_data, 32'hCAFEBABE);
    step();

    // Same-address read/write
    rs1_addr = 5'd5; rd_addr = 5'd5; rd_data = 32'h12345678; rd_we = 1'b1;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("same_addr_before", rs1_data, 32'h12345678);
`else
    chk("same_addr_before", rs1_data, 32'h0);
`endif
    @(posedge clk);
    #1;
    chk("same_addr_after", rs1_data, 32'h12345678);
    rd_we = 1'b0;
    step();

    // Write-enable gating
    rd_we = 1'b0; rd_addr = 5'd4; rd_data = 32'h55AA55AA;
    step();
    step();
    rs1_addr = 5'd4;
    #1;
    chk("we_gating_x4", rs1_data, 32'h0);

    // Top register and both ports on one address
    rd_we = 1'b1; rd_addr = 5'd31; rd_data = 32'h80000001;
    step();
    rd_addr = 5'd17; rd_data = 32'h0000FFFF;
    step();
    rd_we = 1'b0; rs1_addr = 5'd31; rs2_addr = 5'd31;
    #1;
    chk("x31_rs1", rs1_data, 32'h80000001);
    chk("x31_rs2", rs2_data, 32'h80000001);
    rs1_addr = 5'd17;
    #1;
    chk("x17_rs1", rs1_data, 32'h0000FFFF);
    step();

    // Reset priority over a simultaneous write; no forwarding during reset
    rst = 1'b1; rd_we = 1'b1; rd_addr = 5'd3; rd_data = 32'hA5A5A5A5;
    rs1_addr = 5'd3; rs2_addr = 5'd1;
    #1;
    chk("rst_no_forward_x3", rs1_data, 32'h0);
    chk("rst_pre_edge_x1", rs2_data, 32'hDEADBEEF);
    step();
    rst = 1'b0; rd_we = 1'b0;
    #1;
    chk("rst_prio_x3", rs1_data, 32'h0);
    chk("rst_clears_x1", rs2_data, 32'h0);
    rs1_addr = 5'd31;
    #1;
    chk("rst_clears_x31", rs1_data, 32'h0);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
